multi_channel_clock_divider: RTL and testbench
==============================================

// Module: multi_channel_clock_divider
// PURPOSE
//   C-channel programmable clock-enable/divider generator; next generation of the single-channel
//   dynamic divider. Each channel has its own N-bit divisor, enable and output mode (square/pulse).
//   Divisor and mode changes are shadow-loaded only at a phase boundary (glitch-free).
//   A global sync re-phases all channels. Drives slow-rate logic (e.g. mood/timer ticks)
//   from the single system clock.
// PARAMETERS
//   N  4  divisor width per channel (N>=1)
//   C  4  number of channels (C>=1)
// PORTS
//   clk      in   1    system clock; all logic on rising edge
//   rst_n    in   1    synchronous reset, active-low
//   en       in   C    per-channel enable; en[i]=0 holds channel i idle
//   mode     in   C    per-channel mode: 0 = square wave, 1 = one-cycle pulse
//   div      in   C*N  packed divisors; channel i = div[i*N +: N]
//   sync     in   1    global restart, one-cycle strobe or level
//   clk_out  out  C    per-channel divided output, registered
//   tick     out  C    one-cycle strobe at each channel phase boundary, registered
// BEHAVIOUR
// - Per channel i, registers: cnt (N bit), act_div (N bit), act_mode (1 bit), clk_out[i], tick[i].
// - Reset (rst_n=0 at edge): cnt=0, act_div=0, act_mode=0, clk_out=0, tick=0, all channels.
// - Priority at each edge: rst_n=0 > sync=1 > en[i]=0 > counting.
// - sync=1 (all channels) or en[i]=0 (channel i):
//   - cnt<=0, clk_out<=0, tick<=0.
//   - act_div<=div[i], act_mode<=mode[i].
//   - Held every cycle while asserted.
// - Counting (en[i]=1, sync=0), terminal = (cnt==act_div):
//   - Terminal:
//     - cnt<=0, tick<=1.
//     - act_div<=div[i], act_mode<=mode[i] (shadow load).
//     - New act_mode=0: clk_out<=~clk_out.
//     - New act_mode=1: clk_out<=1.
//   - Not terminal:
//     - cnt<=cnt+1, tick<=0.
//     - act_mode=1: clk_out<=0.
//     - act_mode=0: clk_out holds.
// - Square mode: half-period act_div+1 cycles, period 2*(act_div+1); 50% duty.
//   - div=0: period 2 (clk_out toggles every cycle).
// - Pulse mode: clk_out high 1 cycle every act_div+1 cycles.
//   - div=0: clk_out continuously high, tick continuously high.
// - Latency after release: first tick/edge occurs on the (act_div+1)-th enabled edge
//   after en rises or sync falls; act_div is the value captured while idle.
// - Divisor/mode change mid-phase: no effect until the next terminal. The current phase
//   always completes with the old act_div, so there are no runt pulses.
// - Max divisor 2^N-1: cnt never wraps beyond act_div; no overflow possible.
// - Channels are fully independent except for the shared sync.
//   After a common sync release, equal divisors give phase-aligned outputs.
// - Reset mid-operation: all state returns to reset values on that edge, regardless of other inputs.
// - No combinational path from inputs to outputs.
// TESTING
// - Reset: rst_n=0 for 3 cycles with en=all ones, div=all 3
//   -> clk_out=0, tick=0 throughout; release -> first tick on 1st enabled edge (act_div=0 captured).
// - Square, N=4, ch0 div=3, mode=0, en from idle
//   -> clk_out0 toggles every 4 cycles (period 8); tick0 every 4th cycle.
// - Pulse, ch1 div=4, mode=1 -> clk_out1 high 1 of every 5 cycles; div=0 -> clk_out1 stuck high.
// - Glitch-free change: ch0 div=7, change div to 1 at cnt=2
//   -> current half-period still 8 cycles, then half-periods of 2.
// - sync mid-run, ch0 div=2 / ch2 div=2 at different phases, 1-cycle sync
//   -> both clk_out=0, then toggle on the same edge 3 cycles later.
// - en drop: en[3]=0 while clk_out3=1 -> next edge clk_out3=0, tick3=0; other channels unaffected.

Source files
------------

// File: rtl/multi_channel_clock_divider.sv
// Purpose : C-channel programmable divider producing a square or one-cycle pulse output plus a
//           phase-boundary tick per channel. Divisor/mode are shadow-loaded only at a phase
//           boundary, so changes never produce runt pulses.
// Latency : outputs registered; first tick lands on the (act_div+1)-th enabled edge after
//           en rises or sync falls.
// Backpressure: none; free-running, and en/sync hold channels idle.
// Ports:
//   clk      system clock, rising edge
//   rst_n    synchronous reset, active-low
//   en[C]    per-channel enable (0 = idle, captures div/mode)
//   mode[C]  per-channel mode: 0 square, 1 pulse
//   div[C*N] packed divisors, channel i = div[i*N +: N]
//   sync     global restart, held channels idle while high
//   clk_out  per-channel divided output
//   tick     per-channel one-cycle phase-boundary strobe
module multi_channel_clock_divider #(
  parameter int N = 4,
  parameter int C = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [C-1:0]   en,
  input  logic [C-1:0]   mode,
  input  logic [C*N-1:0] div,
  input  logic           sync,
  output logic [C-1:0]   clk_out,
  output logic [C-1:0]   tick
);

  logic [C-1:0][N-1:0] cnt_q,      cnt_d;
  logic [C-1:0][N-1:0] act_div_q,  act_div_d;
  logic [C-1:0]        act_mode_q, act_mode_d;
  logic [C-1:0]        clk_out_q,  clk_out_d;
  logic [C-1:0]        tick_q,     tick_d;

  always_comb begin
    cnt_d      = cnt_q;
    act_div_d  = act_div_q;
    act_mode_d = act_mode_q;
    clk_out_d  = clk_out_q;
    tick_d     = tick_q;
    for (int i = 0; i < C; i++) begin
      if (sync || !en[i]) begin
        // Idle: keep re-capturing the programmed settings so release starts
        // from whatever div/mode is present on the last idle edge.
        cnt_d[i]      = '0;
        clk_out_d[i]  = 1'b0;
        tick_d[i]     = 1'b0;
        act_div_d[i]  = div[i*N +: N];
        act_mode_d[i] = mode[i];
      end else if (cnt_q[i] == act_div_q[i]) begin
        // Phase boundary: shadow load, and the newly loaded mode decides
        // how clk_out behaves for the phase that starts here.
        cnt_d[i]      = '0;
        tick_d[i]     = 1'b1;
        act_div_d[i]  = div[i*N +: N];
        act_mode_d[i] = mode[i];
        clk_out_d[i]  = mode[i] ? 1'b1 : ~clk_out_q[i];
      end else begin
        // cnt stops at act_div, so it can never wrap.
        cnt_d[i]  = cnt_q[i] + N'(1);
        tick_d[i] = 1'b0;
        if (act_mode_q[i]) begin
          clk_out_d[i] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      act_div_q  <= '0;
      act_mode_q <= '0;
      clk_out_q  <= '0;
      tick_q     <= '0;
    end else begin
      cnt_q      <= cnt_d;
      act_div_q  <= act_div_d;
      act_mode_q <= act_mode_d;
      clk_out_q  <= clk_out_d;
      tick_q     <= tick_d;
    end
  end

  assign clk_out = clk_out_q;
  assign tick    = tick_q;

endmodule

// File: tb/tb_multi_channel_clock_divider.sv
// Purpose : directed self-checking bench for multi_channel_clock_divider (N=4, C=4).
// Latency : expectations are queued before each edge and compared 1 time unit after it.
// Backpressure: not applicable.
module tb_multi_channel_clock_divider;
  localparam int N = 4;
  localparam int C = 4;

  logic           clk;
  logic           rst_n;
  logic [C-1:0]   en;
  logic [C-1:0]   mode;
  logic [C*N-1:0] div;
  logic           sync;
  logic [C-1:0]   clk_out;
  logic [C-1:0]   tick;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string        tag;
    logic [C-1:0] m;
    logic [C-1:0] co;
    logic [C-1:0] tk;
  } exp_t;

  exp_t sb[$];

  multi_channel_clock_divider #(.N(N), .C(C)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .mode    (mode),
    .div     (div),
    .sync    (sync),
    .clk_out (clk_out),
    .tick    (tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Queue the expectation, advance one edge, then compare what the DUT registered.
  task automatic step(input string tag, input logic [C-1:0] m,
                      input logic [C-1:0] co, input logic [C-1:0] tk);
    exp_t e;
    e.tag = tag; e.m = m; e.co = co; e.tk = tk;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    checks++;
    assert ((clk_out & e.m) === (e.co & e.m)) else begin
      errors++;
      $error("FAIL %s clk_out=%b expected %b (mask %b)", e.tag, clk_out, e.co, e.m);
    end
    checks++;
    assert ((tick & e.m) === (e.tk & e.m)) else begin
      errors++;
      $error("FAIL %s tick=%b expected %b (mask %b)", e.tag, tick, e.tk, e.m);
    end
  endtask

  // Expected output after k enabled edges from idle with divisor d.
  function automatic logic sq_clk(input int d, input int k);
    return ((k / (d + 1)) % 2) == 1;
  endfunction

  function automatic logic at_bound(input int d, input int k);
    return (k % (d + 1)) == 0;
  endfunction

  initial begin
    int           dv [C];
    logic [C-1:0] md;
    logic [C-1:0] co, tk;

    rst_n = 1'b0; en = '1; mode = '0; sync = 1'b0;
    div = {4'd3, 4'd3, 4'd3, 4'd3};

    // Reset held for three edges.
    for (int i = 0; i < 3; i++) step("reset", 4'hF, 4'h0, 4'h0);

    // Release: act_div=0 from reset gives an immediate boundary, then div=3 takes over.
    rst_n = 1'b1;
    step("rel_first", 4'hF, 4'hF, 4'hF);
    for (int i = 0; i < 3; i++) step("rel_count", 4'hF, 4'hF, 4'h0);
    step("rel_bound", 4'hF, 4'h0, 4'hF);

    // Mixed modes: ch0 square/3, ch1 pulse/4, ch2 square/0, ch3 pulse/0.
    en = '0;
    div = {4'd0, 4'd0, 4'd4, 4'd3};
    mode = 4'b1010;
    step("idle_a", 4'hF, 4'h0, 4'h0);
    dv = '{3, 4, 0, 0};
    md = 4'b1010;
    en = '1;
    for (int k = 1; k <= 24; k++) begin
      for (int c = 0; c < C; c++) begin
        tk[c] = at_bound(dv[c], k);
        co[c] = md[c] ? at_bound(dv[c], k) : sq_clk(dv[c], k);
      end
      step("mixed", 4'hF, co, tk);
    end

    // Divisor change mid-phase on ch0: 7 -> 1 after two counts.
    en = '0;
    div = {4'd0, 4'd0, 4'd0, 4'd7};
    mode = '0;
    step("idle_b", 4'hF, 4'h0, 4'h0);
    en = 4'b0001;
    for (int k = 1; k <= 15; k++) begin
      if (k < 8) begin
        co = 4'h0; tk = 4'h0;
      end else begin
        tk = {3'b000, ((k - 8) % 2) == 0};
        co = {3'b000, (((k - 8) / 2) % 2) == 0};
      end
      step("glitch_free", 4'b0001, co, tk);
      if (k == 2) div[3:0] = 4'd1;
    end

    // Sync re-phases ch0 and ch2 (both div=2) started at different times.
    en = '0;
    div = {4'd0, 4'd2, 4'd0, 4'd2};
    step("idle_c", 4'hF, 4'h0, 4'h0);
    en = 4'b0001;
    step("sync_pre1", 4'b0001, 4'h0, 4'h0);
    step("sync_pre2", 4'b0001, 4'h0, 4'h0);
    en = 4'b0101;
    step("sync_pre3", 4'b0101, 4'b0001, 4'b0001);
    step("sync_pre4", 4'b0101, 4'b0001, 4'b0000);
    sync = 1'b1;
    step("sync_edge", 4'b0101, 4'h0, 4'h0);
    sync = 1'b0;
    step("sync_post1", 4'b0101, 4'h0, 4'h0);
    step("sync_post2", 4'b0101, 4'h0, 4'h0);
    step("sync_align", 4'b0101, 4'b0101, 4'b0101);

    // Drop en[3] while clk_out3 is high; ch0 keeps counting.
    en = '0;
    div = {4'd1, 4'd0, 4'd0, 4'd3};
    step("idle_d", 4'hF, 4'h0, 4'h0);
    en = 4'b1001;
    step("endrop_k1", 4'b1001, 4'h0, 4'h0);
    step("endrop_k2", 4'b1001, 4'b1000, 4'b1000);
    en = 4'b0001;
    step("endrop_off", 4'b1001, 4'h0, 4'h0);
    step("endrop_ch0", 4'b1001, 4'b0001, 4'b0001);

    // Reset mid-run overrides enable and sync.
    en = '1; sync = 1'b1; rst_n = 1'b0;
    step("reset_mid", 4'hF, 4'h0, 4'h0);
    rst_n = 1'b1; sync = 1'b0; mode = '0;
    step("reset_rel", 4'hF, 4'hF, 4'hF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
